// File: rtl/seg_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_controller
//  Description : Parametrised multiplexed 7-segment display driver. Scans
//                NUM_DIGITS digits, takes new content through a load/shadow
//                handshake that only reaches the display at a frame boundary,
//                decodes hex or decimal glyphs, blanks leading zeros, drives
//                decimal points and applies PWM brightness to the anodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_controller #(
    parameter int NUM_DIGITS    = 4,
    parameter int SCAN_DIV_LOG2 = 19,
    parameter int BRIGHT_BITS   = 4,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    hex_mode,
    input  logic                    blank_lz,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    input  logic                    enable,
    output logic [NUM_DIGITS-1:0]   digits,
    output logic [6:0]              segments,
    output logic                    dp_out,
    output logic                    frame_tick
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [c_IDX_W-1:0]    c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_IDX_W-1:0]    c_IDX_ZERO = '0;
    // XOR masks that turn active-high internal levels into pin levels
    localparam logic [NUM_DIGITS-1:0] c_DIG_POL  = {NUM_DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]            c_SEG_POL  = {7{ACTIVE_LOW}};
    // Glyph shown for 10..15 in decimal mode: the middle bar only
    localparam logic [6:0]            c_GLYPH_DASH = 7'b1000000;

    // ------------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------------
    logic [SCAN_DIV_LOG2-1:0] r_div_cnt;
    logic [c_IDX_W-1:0]       r_idx;
    logic                     w_wrap;
    logic                     w_boundary;

    // Shadow (written by load) and display (what is actually scanned out)
    logic [4*NUM_DIGITS-1:0]  r_sh_value;
    logic [NUM_DIGITS-1:0]    r_sh_dp;
    logic                     r_sh_hex;
    logic                     r_sh_blz;
    logic                     r_pending;

    logic [4*NUM_DIGITS-1:0]  r_disp_value;
    logic [NUM_DIGITS-1:0]    r_disp_dp;
    logic                     r_disp_hex;
    logic                     r_disp_blz;

    logic                     r_frame_tick;

    // Per-cycle decode of the currently selected digit
    logic [NUM_DIGITS-1:0]    w_sel;
    logic [3:0]               w_nib;
    logic [NUM_DIGITS-1:0]    w_blank_vec;
    logic                     w_zero_run;
    logic                     w_blank;
    logic                     w_dp_req;
    logic [6:0]               w_glyph;
    logic                     w_pwm_on;
    logic                     w_anode_on;

    // Registered pin drivers
    logic [NUM_DIGITS-1:0]    r_digits;
    logic [6:0]               r_segments;
    logic                     r_dp;

    assign w_wrap     = &r_div_cnt;
    assign w_boundary = w_wrap && (r_idx == c_IDX_ZERO);

    // Free-running divider; the digit index steps down on every wrap
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_idx     <= c_IDX_LAST;
        end else begin
            r_div_cnt <= r_div_cnt + SCAN_DIV_LOG2'(1);
            if (w_wrap) begin
                if (r_idx == c_IDX_ZERO) begin
                    r_idx <= c_IDX_LAST;
                end else begin
                    r_idx <= r_idx - c_IDX_W'(1);
                end
            end
        end
    end

    // Shadow capture: the most recent load before a boundary wins
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_sh_value <= '0;
            r_sh_dp    <= '0;
            r_sh_hex   <= 1'b0;
            r_sh_blz   <= 1'b0;
        end else if (load) begin
            r_sh_value <= value;
            r_sh_dp    <= dp_in;
            r_sh_hex   <= hex_mode;
            r_sh_blz   <= blank_lz;
        end
    end

    // Pending flag: a load on the boundary cycle itself stays pending for
    // the following boundary, since the shadow it writes is not yet visible
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pending <= 1'b0;
        end else if (load) begin
            r_pending <= 1'b1;
        end else if (w_boundary) begin
            r_pending <= 1'b0;
        end
    end

    // Display copy only changes between frames so a frame is never torn
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_disp_value <= '0;
            r_disp_dp    <= '0;
            r_disp_hex   <= 1'b0;
            r_disp_blz   <= 1'b0;
        end else if (w_boundary && r_pending) begin
            r_disp_value <= r_sh_value;
            r_disp_dp    <= r_sh_dp;
            r_disp_hex   <= r_sh_hex;
            r_disp_blz   <= r_sh_blz;
        end
    end

    // One-cycle pulse following every frame boundary
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_boundary;
        end
    end

    // One-hot select of the current digit and its nibble
    always_comb begin
        w_sel = '0;
        w_nib = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_sel[i] = 1'b1;
                w_nib    = r_disp_value[4*i +: 4];
            end
        end
    end

    // Leading-zero mask: walk from the leftmost digit while nibbles are zero;
    // digit 0 is left out of the walk so it always shows something
    always_comb begin
        w_blank_vec = '0;
        w_zero_run  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            w_zero_run     = w_zero_run && (r_disp_value[4*i +: 4] == 4'd0);
            w_blank_vec[i] = r_disp_blz && w_zero_run;
        end
    end

    assign w_blank  = |(w_blank_vec & w_sel);
    assign w_dp_req = |(r_disp_dp & w_sel);

    // Nibble to active-high {g,f,e,d,c,b,a}; 10..15 collapse to a dash
    // unless hex glyphs are selected
    always_comb begin
        w_glyph = 7'b0000000;
        case (w_nib)
            4'h0: w_glyph = 7'b0111111;
            4'h1: w_glyph = 7'b0000110;
            4'h2: w_glyph = 7'b1011011;
            4'h3: w_glyph = 7'b1001111;
            4'h4: w_glyph = 7'b1100110;
            4'h5: w_glyph = 7'b1101101;
            4'h6: w_glyph = 7'b1111101;
            4'h7: w_glyph = 7'b0000111;
            4'h8: w_glyph = 7'b1111111;
            4'h9: w_glyph = 7'b1101111;
            4'hA: w_glyph = 7'b1110111;
            4'hB: w_glyph = 7'b1111100;
            4'hC: w_glyph = 7'b0111001;
            4'hD: w_glyph = 7'b1011110;
            4'hE: w_glyph = 7'b1111001;
            4'hF: w_glyph = 7'b1110001;
            default: w_glyph = 7'b0000000;
        endcase
        if (!r_disp_hex && (w_nib > 4'd9)) begin
            w_glyph = c_GLYPH_DASH;
        end
    end

    // PWM compares the top bits of the divider, so brightness=0 still
    // yields the first slice of each digit period
    assign w_pwm_on   = (r_div_cnt[SCAN_DIV_LOG2-1 -: BRIGHT_BITS] <= brightness);
    assign w_anode_on = enable && !w_blank && w_pwm_on;

    // Pin registers: at most one anode since w_sel is one-hot
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_digits   <= c_DIG_POL;
            r_segments <= c_SEG_POL;
            r_dp       <= ACTIVE_LOW;
        end else begin
            r_digits   <= (w_anode_on ? w_sel : '0) ^ c_DIG_POL;
            r_segments <= (w_blank ? 7'b0000000 : w_glyph) ^ c_SEG_POL;
            r_dp       <= (w_dp_req && !w_blank) ^ ACTIVE_LOW;
        end
    end

    assign digits     = r_digits;
    assign segments   = r_segments;
    assign dp_out     = r_dp;
    assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_controller
//  Description : Directed self-checking bench for seg_scan_controller with
//                SCAN_DIV_LOG2=4, NUM_DIGITS=4, BRIGHT_BITS=2, ACTIVE_LOW=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_controller;

    logic        CLK = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        hex_mode;
    logic        blank_lz;
    logic [1:0]  brightness;
    logic        enable;
    logic [3:0]  digits;
    logic [6:0]  segments;
    logic        dp_out;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    // Active-low glyph constants
    localparam logic [6:0] G0    = 7'b1000000;
    localparam logic [6:0] G1    = 7'b1111001;
    localparam logic [6:0] G2    = 7'b0100100;
    localparam logic [6:0] G3    = 7'b0110000;
    localparam logic [6:0] G4    = 7'b0011001;
    localparam logic [6:0] G5    = 7'b0010010;
    localparam logic [6:0] G7    = 7'b1111000;
    localparam logic [6:0] GA    = 7'b0001000;
    localparam logic [6:0] GF    = 7'b0001110;
    localparam logic [6:0] GDASH = 7'b0111111;
    localparam logic [6:0] GOFF  = 7'b1111111;

    seg_scan_controller #(
        .NUM_DIGITS    (4),
        .SCAN_DIV_LOG2 (4),
        .BRIGHT_BITS   (2),
        .ACTIVE_LOW    (1'b1)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .value      (value),
        .dp_in      (dp_in),
        .load       (load),
        .hex_mode   (hex_mode),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .enable     (enable),
        .digits     (digits),
        .segments   (segments),
        .dp_out     (dp_out),
        .frame_tick (frame_tick)
    );

    always #5 CLK = ~CLK;

    // Waits (bounded) for the negedge at which frame_tick is high
    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One-cycle load pulse, starting at a negedge
    task automatic do_load(input logic [15:0] v, input logic [3:0] dp,
                           input logic hx, input logic bz);
        value    = v;
        dp_in    = dp;
        hex_mode = hx;
        blank_lz = bz;
        load     = 1'b1;
        @(negedge CLK);
        load     = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (digits !== 4'b1111) begin
            errors++; $display("FAIL reset_digits: got %b expected 1111", digits);
        end
        checks++;
        if (segments !== GOFF) begin
            errors++; $display("FAIL reset_segments: got %b expected %b", segments, GOFF);
        end
        checks++;
        if (dp_out !== 1'b1) begin
            errors++; $display("FAIL reset_dp: got %b expected 1", dp_out);
        end
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++; $display("FAIL reset_tick: got %b expected 0", frame_tick);
        end
        reset = 1'b0;
    endtask

    task automatic test_load_basic;
        logic [6:0] exp_seg [4];
        logic [3:0] ed;
        int d;
        int bad;
        bit ok;
        exp_seg[3] = G1; exp_seg[2] = G2; exp_seg[1] = G3; exp_seg[0] = G4;
        do_load(16'h1234, 4'b0000, 1'b0, 1'b0);
        bad = 0;
        ok  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (segments !== G0) bad++;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL load_basic_tick: frame_tick not seen within 200 cycles");
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL load_basic_pre_tick: %0d samples not %b before first tick", bad, G0);
        end
        for (int n = 1; n <= 64; n++) begin
            @(negedge CLK);
            d  = 3 - (n - 1) / 16;
            ed = 4'b1111;
            ed[d] = 1'b0;
            checks++;
            if (digits !== ed) begin
                errors++; $display("FAIL load_basic_digits n=%0d: got %b expected %b", n, digits, ed);
            end
            checks++;
            if (segments !== exp_seg[d]) begin
                errors++; $display("FAIL load_basic_segments n=%0d: got %b expected %b", n, segments, exp_seg[d]);
            end
            checks++;
            if (dp_out !== 1'b1) begin
                errors++; $display("FAIL load_basic_dp n=%0d: got %b expected 1", n, dp_out);
            end
        end
    endtask

    task automatic test_blank_lz;
        logic [3:0] exp_dig [4];
        logic       exp_dp  [4];
        int d;
        bit ok;
        exp_dig[3] = 4'b1111; exp_dig[2] = 4'b1111; exp_dig[1] = 4'b1101; exp_dig[0] = 4'b1110;
        exp_dp[3]  = 1'b1;    exp_dp[2]  = 1'b1;    exp_dp[1]  = 1'b0;    exp_dp[0]  = 1'b1;
        wait_tick(ok);
        do_load(16'h0070, 4'b0110, 1'b0, 1'b1);
        wait_tick(ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL blank_lz_tick: frame_tick not seen within 200 cycles");
        end
        for (int n = 1; n <= 64; n++) begin
            @(negedge CLK);
            d = 3 - (n - 1) / 16;
            checks++;
            if (digits !== exp_dig[d]) begin
                errors++; $display("FAIL blank_lz_digits n=%0d: got %b expected %b", n, digits, exp_dig[d]);
            end
            checks++;
            if (dp_out !== exp_dp[d]) begin
                errors++; $display("FAIL blank_lz_dp n=%0d: got %b expected %b", n, dp_out, exp_dp[d]);
            end
            if (d == 1) begin
                checks++;
                if (segments !== G7) begin
                    errors++; $display("FAIL blank_lz_seg1 n=%0d: got %b expected %b", n, segments, G7);
                end
            end else if (d == 0) begin
                checks++;
                if (segments !== G0) begin
                    errors++; $display("FAIL blank_lz_seg0 n=%0d: got %b expected %b", n, segments, G0);
                end
            end
        end
    endtask

    task automatic test_glyph_modes;
        logic [6:0] exp_seg [4];
        int d;
        bit ok;
        for (int pass = 0; pass < 2; pass++) begin
            exp_seg[3] = G0;
            exp_seg[2] = G0;
            exp_seg[1] = (pass == 0) ? GDASH : GA;
            exp_seg[0] = (pass == 0) ? GDASH : GF;
            wait_tick(ok);
            do_load(16'h00AF, 4'b0000, (pass == 1), 1'b0);
            wait_tick(ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL glyph_tick pass=%0d: frame_tick not seen", pass);
            end
            for (int n = 1; n <= 64; n++) begin
                @(negedge CLK);
                d = 3 - (n - 1) / 16;
                checks++;
                if (segments !== exp_seg[d]) begin
                    errors++; $display("FAIL glyph_seg pass=%0d n=%0d: got %b expected %b", pass, n, segments, exp_seg[d]);
                end
            end
        end
    endtask

    task automatic test_last_load_wins;
        int bad;
        bit ok;
        wait_tick(ok);
        do_load(16'h1111, 4'b0000, 1'b0, 1'b0);
        repeat (10) @(negedge CLK);
        do_load(16'h2222, 4'b0000, 1'b0, 1'b0);
        bad = 0;
        ok  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (segments === G1) bad++;
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL last_load_tick: frame_tick not seen within 200 cycles");
        end
        for (int n = 1; n <= 64; n++) begin
            @(negedge CLK);
            if (segments === G1) bad++;
            checks++;
            if (segments !== G2) begin
                errors++; $display("FAIL last_load_seg n=%0d: got %b expected %b", n, segments, G2);
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL last_load_no1111: glyph 1 seen in %0d samples, expected 0", bad);
        end
    endtask

    task automatic test_load_on_boundary;
        logic [6:0] es;
        int d;
        bit ok;
        wait_tick(ok);
        repeat (63) @(negedge CLK);
        do_load(16'h5555, 4'b0000, 1'b0, 1'b0);
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++; $display("FAIL boundary_load_tick: got %b expected 1", frame_tick);
        end
        for (int n = 1; n <= 128; n++) begin
            @(negedge CLK);
            d  = 3 - ((n - 1) % 64) / 16;
            es = (n <= 64) ? G2 : G5;
            checks++;
            if (segments !== es) begin
                errors++; $display("FAIL boundary_load_seg n=%0d digit=%0d: got %b expected %b", n, d, segments, es);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [3:0] ed;
        int d;
        int bad;
        bit ok;
        wait_tick(ok);
        repeat (5) @(negedge CLK);
        do_load(16'h3333, 4'b1111, 1'b1, 1'b0);
        repeat (10) @(negedge CLK);
        reset = 1'b1;
        @(negedge CLK);
        checks++;
        if (digits !== 4'b1111) begin
            errors++; $display("FAIL midreset_digits: got %b expected 1111", digits);
        end
        checks++;
        if (segments !== GOFF) begin
            errors++; $display("FAIL midreset_segments: got %b expected %b", segments, GOFF);
        end
        checks++;
        if (dp_out !== 1'b1) begin
            errors++; $display("FAIL midreset_dp: got %b expected 1", dp_out);
        end
        reset = 1'b0;
        bad = 0;
        ok  = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLK);
            if (frame_tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (segments !== G0) bad++;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL midreset_tick: frame_tick not seen within 200 cycles");
        end
        for (int n = 1; n <= 64; n++) begin
            @(negedge CLK);
            d  = 3 - (n - 1) / 16;
            ed = 4'b1111;
            ed[d] = 1'b0;
            if (segments !== G0 || digits !== ed || dp_out !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL midreset_discard: %0d samples not showing zero display, expected 0", bad);
        end
    endtask

    task automatic test_pwm;
        int cnt [4];
        int stray;
        int d;
        int exp_on;
        bit ok;
        wait_tick(ok);
        for (int pass = 0; pass < 2; pass++) begin
            brightness = (pass == 0) ? 2'd1 : 2'd0;
            exp_on     = (pass == 0) ? 8 : 4;
            for (int i = 0; i < 4; i++) cnt[i] = 0;
            stray = 0;
            for (int n = 1; n <= 64; n++) begin
                @(negedge CLK);
                d = 3 - (n - 1) / 16;
                if (digits[d] === 1'b0) cnt[d]++;
                if ((digits | (4'b0001 << d)) !== 4'b1111) stray++;
            end
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cnt[i] != exp_on) begin
                    errors++; $display("FAIL pwm_duty b=%0d digit=%0d: got %0d on-cycles expected %0d", brightness, i, cnt[i], exp_on);
                end
            end
            checks++;
            if (stray != 0) begin
                errors++; $display("FAIL pwm_stray b=%0d: %0d samples with a wrong anode, expected 0", brightness, stray);
            end
        end
        brightness = 2'd3;
    endtask

    task automatic test_enable_off;
        int bad;
        int len;
        bit ok;
        wait_tick(ok);
        enable = 1'b0;
        for (int iv = 0; iv < 2; iv++) begin
            bad = 0;
            len = 0;
            ok  = 1'b0;
            for (int k = 0; k < 200; k++) begin
                @(negedge CLK);
                len++;
                if (digits !== 4'b1111) bad++;
                if (frame_tick === 1'b1) begin
                    ok = 1'b1;
                    break;
                end
            end
            checks++;
            if (!ok || len != 64) begin
                errors++; $display("FAIL enable_off_period iv=%0d: got %0d cycles expected 64", iv, len);
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL enable_off_dark iv=%0d: %0d lit samples expected 0", iv, bad);
            end
        end
        enable = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        value      = 16'h0000;
        dp_in      = 4'b0000;
        load       = 1'b0;
        hex_mode   = 1'b0;
        blank_lz   = 1'b0;
        brightness = 2'd3;
        enable     = 1'b1;
        test_reset();
        test_load_basic();
        test_blank_lz();
        test_glyph_modes();
        test_last_load_wins();
        test_load_on_boundary();
        test_reset_mid_frame();
        test_pwm();
        test_enable_off();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
